// File: rtl/rackbus_pkg.sv
// RACKbus TX gearbox shared types and constants.
// The optional PRBS idle fill is enabled by defining RACKBUS_TX_PRBS_EN.
package rackbus_pkg;

    typedef logic [1:0] rb_phase_t;

    localparam int RB_TX_WORD_W       = 32;
    localparam int RB_TX_BEAT_W       = 24;
    localparam int RB_BEATS_PER_FRAME = 4;
    localparam int RB_WORDS_PER_FRAME = 3;

    // Last phase of a sync period, and last phase in which a word is taken.
    localparam rb_phase_t RB_LAST_PHASE      = rb_phase_t'(RB_BEATS_PER_FRAME - 1);
    localparam rb_phase_t RB_LAST_WORD_PHASE = rb_phase_t'(RB_WORDS_PER_FRAME - 1);

    // PRBS-15, polynomial x^15 + x^14 + 1.
    localparam int          RB_PRBS15_TAP_A = 14;
    localparam int          RB_PRBS15_TAP_B = 13;
    localparam logic [14:0] RB_PRBS15_SEED  = 15'h7FFF;

    function automatic logic [14:0] prbs15_next(input logic [14:0] state);
        return {state[13:0], state[RB_PRBS15_TAP_A] ^ state[RB_PRBS15_TAP_B]};
    endfunction

endpackage

// File: rtl/rackbus_tx_gearbox_if.sv
// Stream interface of the RACKbus TX gearbox: 32-bit word input, 24-bit beat output.
interface rackbus_tx_gearbox_if;
    import rackbus_pkg::*;

    logic [RB_TX_WORD_W-1:0] din;
    logic                    din_valid;
    logic                    din_ready;
    logic [RB_TX_BEAT_W-1:0] dout;
    logic                    dout_valid;

    // Gearbox side.
    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output dout,
        output dout_valid
    );

    // Source / serializer side.
    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  dout,
        input  dout_valid
    );
endinterface

// File: rtl/rackbus_tx_phase_track.sv
// Phase tracker: 2-bit period-4 counter realigned by sync_i, lock flag and
// detection of sync pulses that arrive at an unexpected phase.
module rackbus_tx_phase_track
    import rackbus_pkg::*;
(
    input  logic      txclk,
    input  logic      rst_n,
    input  logic      sync_i,
    output rb_phase_t phase_o,      // phase of the current cycle
    output logic      locked_o,
    output logic      sync_err_o    // combinational, current cycle
);

    rb_phase_t phase_q, phase_d;
    logic      locked_q, locked_d;

    // Next phase / lock state; a sync pulse takes effect in its own cycle.
    always_comb begin
        phase_d    = phase_q + 2'd1;
        locked_d   = locked_q;
        sync_err_o = 1'b0;
        if (sync_i) begin
            phase_d    = 2'd0;
            locked_d   = 1'b1;
            sync_err_o = locked_q & (phase_q != RB_LAST_PHASE);
        end else begin
            phase_d    = phase_q + 2'd1;
        end
    end

    // Phase and lock registers.
    always_ff @(posedge txclk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= 2'd0;
            locked_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            locked_q <= locked_d;
        end
    end

    assign phase_o  = phase_d;
    assign locked_o = locked_q;

endmodule

// File: rtl/rackbus_tx_gearbox.sv
// RACKbus transmit 3:4 gearbox: three 32-bit words per sync period become
// four 24-bit beats. Optional macro RACKBUS_TX_PRBS_EN fills invalid beats
// with PRBS-15 instead of zero.
module rackbus_tx_gearbox
    import rackbus_pkg::*;
#(
    parameter logic [RB_TX_WORD_W-1:0] IDLE_WORD = 32'h0000_00BC,
    parameter int                      ERR_CNT_W = 8
) (
    input  logic                 txclk,
    input  logic                 rst_n,
    input  logic                 sync_i,
    rackbus_tx_gearbox_if.slave  bus,
    output logic                 locked_o,
    output logic                 sync_err_o,
    output logic                 underrun_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    rb_phase_t               phase_s;
    logic                    locked_s;
    logic                    sync_err_s;
    logic                    accept_s;
    logic                    underrun_s;
    logic [RB_TX_WORD_W-1:0] word_s;
    logic [RB_TX_BEAT_W-1:0] beat_s;

    logic [RB_TX_BEAT_W-1:0] dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;
    logic [RB_TX_BEAT_W-1:0] res_q, res_d;
    logic                    active_q, active_d;
    logic                    sync_err_q;
    logic                    underrun_q;
    logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;
`ifdef RACKBUS_TX_PRBS_EN
    logic [14:0]             lfsr_q, lfsr_d;
`endif

    rackbus_tx_phase_track u_phase_track (
        .txclk      (txclk),
        .rst_n      (rst_n),
        .sync_i     (sync_i),
        .phase_o    (phase_s),
        .locked_o   (locked_s),
        .sync_err_o (sync_err_s)
    );

    // A misplaced sync aborts the frame, so nothing is taken in that cycle.
    assign bus.din_ready = locked_s & (phase_s != RB_LAST_PHASE)
                         & ((phase_s == 2'd0) | active_q) & ~sync_err_s;
    assign accept_s      = bus.din_ready & bus.din_valid;
    assign word_s        = bus.din_valid ? bus.din : IDLE_WORD;
    assign underrun_s    = active_q & ~bus.din_valid & ~sync_err_s
                         & (phase_s != 2'd0) & (phase_s <= RB_LAST_WORD_PHASE);

    // Beat packing, residual bookkeeping, frame tracking and idle fill.
    always_comb begin
        beat_s       = 24'h0;
        dout_valid_d = 1'b0;
        res_d        = res_q;
        active_d     = active_q;
        dout_d       = 24'h0;
`ifdef RACKBUS_TX_PRBS_EN
        lfsr_d       = lfsr_q;
`endif
        if (sync_err_s) begin
            active_d = 1'b0;
            res_d    = 24'h0;
        end else begin
            case (phase_s)
                2'd0: begin
                    if (accept_s) begin
                        active_d     = 1'b1;
                        dout_valid_d = 1'b1;
                        beat_s       = bus.din[23:0];
                        res_d        = {16'h0, bus.din[31:24]};
                    end else begin
                        active_d     = 1'b0;
                        res_d        = 24'h0;
                    end
                end
                2'd1: begin
                    if (active_q) begin
                        dout_valid_d = 1'b1;
                        beat_s       = {word_s[15:0], res_q[7:0]};
                        res_d        = {8'h0, word_s[31:16]};
                    end else begin
                        res_d        = 24'h0;
                    end
                end
                2'd2: begin
                    if (active_q) begin
                        dout_valid_d = 1'b1;
                        beat_s       = {word_s[7:0], res_q[15:0]};
                        res_d        = word_s[31:8];
                    end else begin
                        res_d        = 24'h0;
                    end
                end
                default: begin
                    dout_valid_d = active_q;
                    beat_s       = res_q;
                    res_d        = 24'h0;
                end
            endcase
        end

        if (dout_valid_d) begin
            dout_d = beat_s;
        end else begin
`ifdef RACKBUS_TX_PRBS_EN
            dout_d = {9'h0, lfsr_q};
            lfsr_d = prbs15_next(lfsr_q);
`else
            dout_d = 24'h0;
`endif
        end
    end

    // Saturating error counter; coincident events count once.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((sync_err_s | underrun_s) && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Output, residual and status registers.
    always_ff @(posedge txclk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= 24'h0;
            dout_valid_q <= 1'b0;
            res_q        <= 24'h0;
            active_q     <= 1'b0;
            sync_err_q   <= 1'b0;
            underrun_q   <= 1'b0;
            err_cnt_q    <= {ERR_CNT_W{1'b0}};
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            res_q        <= res_d;
            active_q     <= active_d;
            sync_err_q   <= sync_err_s;
            underrun_q   <= underrun_s;
            err_cnt_q    <= err_cnt_d;
        end
    end

`ifdef RACKBUS_TX_PRBS_EN
    // Idle-fill LFSR, advanced only on invalid beats.
    always_ff @(posedge txclk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= RB_PRBS15_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign locked_o       = locked_s;
    assign sync_err_o     = sync_err_q;
    assign underrun_o     = underrun_q;
    assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_rackbus_tx_gearbox.sv
// Self-checking bench for rackbus_tx_gearbox with a frame-level reference model.
module tb_rackbus_tx_gearbox;

    localparam logic [31:0] IDLE = 32'h0000_00BC;

    logic       txclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sync_i = 1'b0;
    logic       locked_o, sync_err_o, underrun_o;
    logic [7:0] err_cnt_o;

    rackbus_tx_gearbox_if bus_if();

    rackbus_tx_gearbox dut (
        .txclk      (txclk),
        .rst_n      (rst_n),
        .sync_i     (sync_i),
        .bus        (bus_if),
        .locked_o   (locked_o),
        .sync_err_o (sync_err_o),
        .underrun_o (underrun_o),
        .err_cnt_o  (err_cnt_o)
    );

    always #5 txclk = ~txclk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [1:0]  m_phase;
    bit          m_locked, m_active, m_rdy;
    logic [95:0] m_frame;
    logic [7:0]  m_cnt;
    logic [14:0] m_lfsr;
    logic [23:0] e_dout;
    bit          e_valid, e_se, e_uf;
    int          sph;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 2'd0; m_locked = 0; m_active = 0; m_rdy = 0;
        m_frame = 96'h0; m_cnt = 8'h0; m_lfsr = 15'h7FFF;
        e_dout = 24'h0; e_valid = 0; e_se = 0; e_uf = 0;
    endtask

    task automatic check_outputs();
        check_val("dout",       bus_if.dout,       e_dout);
        check_val("dout_valid", bus_if.dout_valid, e_valid);
        check_val("sync_err",   sync_err_o,        e_se);
        check_val("underrun",   underrun_o,        e_uf);
        check_val("err_cnt",    err_cnt_o,         m_cnt);
        check_val("locked",     locked_o,          m_locked);
    endtask

    // One clock cycle: drive, check ready, advance model, check registered outputs.
    task automatic step(input bit s, input bit v, input logic [31:0] d);
        logic [1:0]  ph;
        logic [31:0] w;
        bit          se, uf;
        @(negedge txclk);
        sync_i = s; bus_if.din_valid = v; bus_if.din = d;
        #1;
        ph    = s ? 2'd0 : m_phase + 2'd1;
        se    = s && m_locked && (m_phase != 2'd3);
        m_rdy = m_locked && (ph != 2'd3) && (ph == 2'd0 || m_active) && !se;
        uf    = !se && m_active && (ph == 2'd1 || ph == 2'd2) && !v;
        w     = v ? d : IDLE;
        check_val("din_ready", bus_if.din_ready, m_rdy);
        e_valid = 0; e_dout = 24'h0;
        if (se) begin
            m_active = 0;
        end else begin
            case (ph)
                2'd0: if (m_rdy && v) begin
                          m_frame = {64'h0, d}; m_active = 1;
                          e_valid = 1; e_dout = m_frame[23:0];
                      end else m_active = 0;
                2'd1: if (m_active) begin
                          m_frame[63:32] = w; e_valid = 1; e_dout = m_frame[47:24];
                      end
                2'd2: if (m_active) begin
                          m_frame[95:64] = w; e_valid = 1; e_dout = m_frame[71:48];
                      end
                default: if (m_active) begin
                          e_valid = 1; e_dout = m_frame[95:72];
                      end
            endcase
        end
`ifdef RACKBUS_TX_PRBS_EN
        if (!e_valid) begin
            e_dout = {9'h0, m_lfsr};
            m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
        end
`endif
        e_se = se; e_uf = uf;
        if (s) m_locked = 1;
        m_phase = ph;
        if ((se || uf) && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        @(posedge txclk);
        #1;
        check_outputs();
    endtask

    // Cycle with bench-generated sync (every 4 cycles unless suppressed or forced).
    task automatic tick(input bit force_sync, input bit no_sync, input bit v, input logic [31:0] d);
        bit s;
        s = ((sph == 0) && !no_sync) || force_sync;
        if (force_sync) sph = 0;
        step(s, v, d);
        sph = (sph + 1) % 4;
    endtask

    function automatic logic [31:0] word_of(input logic [7:0] b);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    logic [7:0]  wb, ob;
    int          nbeat;
    logic [23:0] exp_first [4];

    initial begin
        exp_first[0] = 24'h020100; exp_first[1] = 24'h050403;
        exp_first[2] = 24'h080706; exp_first[3] = 24'h0B0A09;
        bus_if.din = 32'h0; bus_if.din_valid = 1'b0;
        model_reset();
        sph = 0;
        #1;
        check_outputs();
        repeat (2) @(posedge txclk);
        @(negedge txclk);
        rst_n = 1'b1;

        // Lock, then ten back-to-back frames of an incrementing byte stream.
        wb = 8'h00; ob = 8'h00; nbeat = 0;
        for (int i = 0; i < 44; i++) begin
            tick(0, 0, 1, word_of(wb));
            if (m_rdy) wb = wb + 8'd4;
            if (nbeat > 0 && nbeat < 40) check_val("continuous", bus_if.dout_valid, 1'b1);
            if (bus_if.dout_valid) begin
                check_val("byte_order", bus_if.dout, {ob + 8'd2, ob + 8'd1, ob});
                if (nbeat < 4) check_val("first_frame", bus_if.dout, exp_first[nbeat]);
                ob = ob + 8'd3;
                nbeat++;
            end
        end
        check_val("beats_seen", nbeat, 40);

        // No word at phase 0: the whole period stays empty.
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 32'h0);
            check_val("empty_valid", bus_if.dout_valid, 1'b0);
        end

        // Missing second word is replaced by the idle word.
        tick(0, 0, 1, 32'h13121110);
        tick(0, 0, 0, 32'hDEADBEEF);
        check_val("underrun_b1", bus_if.dout, 24'h00BC13);
        check_val("underrun_pulse", underrun_o, 1'b1);
        tick(0, 0, 1, 32'h1B1A1918);
        check_val("underrun_b2", bus_if.dout, 24'h180000);
        check_val("underrun_end", underrun_o, 1'b0);
        tick(0, 0, 1, 32'h0);
        check_val("underrun_cnt", err_cnt_o, 8'd1);

        // Extra sync at phase 1 drops the frame; the following frame is clean.
        tick(0, 0, 1, 32'h23222120);
        tick(1, 0, 1, 32'h27262524);
        check_val("sync_err_pulse", sync_err_o, 1'b1);
        check_val("abort_valid", bus_if.dout_valid, 1'b0);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 32'h55555555);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, word_of(8'h30 + 8'(i * 4)));
        check_val("sync_err_cnt", err_cnt_o, 8'd2);

        // Randomized traffic with occasional misplaced or missing syncs.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(49) == 0), ($urandom_range(29) == 0),
                 ($urandom_range(7) != 0), $urandom);
        end

        // Reset in the middle of a frame.
        while (sph != 0) tick(0, 0, 0, 32'h0);
        tick(0, 0, 1, 32'hA3A2A1A0);
        tick(0, 0, 1, 32'hA7A6A5A4);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge txclk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 1, $urandom);
            check_val("no_relock", bus_if.dout_valid, 1'b0);
        end
        tick(1, 0, 1, 32'h0);
        for (int i = 0; i < 12; i++) tick(0, 0, 1, $urandom);

        // Sync every cycle: a misplaced sync each time, counter saturates.
        for (int i = 0; i < 300; i++) tick(1, 0, 0, 32'h0);
        check_val("err_cnt_sat", err_cnt_o, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
